// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types, board geometry and tetromino offset table
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef enum logic [2:0] {
        SHAPE_I = 3'd0,
        SHAPE_O = 3'd1,
        SHAPE_T = 3'd2,
        SHAPE_S = 3'd3,
        SHAPE_Z = 3'd4,
        SHAPE_J = 3'd5,
        SHAPE_L = 3'd6
    } shape_t;

    typedef enum logic [2:0] {
        ST_SPAWN      = 3'd0,
        ST_FALL       = 3'd1,
        ST_LOCK       = 3'd2,
        ST_WAIT_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } cell_ofs_t;

    // Element 0 is cell 1 of the piece.
    typedef cell_ofs_t [3:0] cells_t;

    function automatic cell_ofs_t ofs(input int dx, input int dy);
        cell_ofs_t c;
        c.dx = 2'(dx);
        c.dy = 2'(dy);
        return c;
    endfunction

    // Code 7 has no shape of its own and plays as an I piece.
    function automatic shape_t to_shape(input logic [2:0] code);
        return (code == 3'd7) ? SHAPE_I : shape_t'(code);
    endfunction

    // Concatenations list cell 4 first so that element 0 lands on cell 1.
    function automatic cells_t shape_cells(input shape_t shape);
        cells_t c;
        case (shape)
            SHAPE_O: c = {ofs(2, 1), ofs(1, 1), ofs(2, 0), ofs(1, 0)};
            SHAPE_T: c = {ofs(1, 1), ofs(2, 0), ofs(1, 0), ofs(0, 0)};
            SHAPE_S: c = {ofs(1, 1), ofs(0, 1), ofs(2, 0), ofs(1, 0)};
            SHAPE_Z: c = {ofs(2, 1), ofs(1, 1), ofs(1, 0), ofs(0, 0)};
            SHAPE_J: c = {ofs(2, 1), ofs(2, 0), ofs(1, 0), ofs(0, 0)};
            SHAPE_L: c = {ofs(0, 1), ofs(2, 0), ofs(1, 0), ofs(0, 0)};
            default: c = {ofs(3, 0), ofs(2, 0), ofs(1, 0), ofs(0, 0)};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/piece_dropper_if.sv
// rtl/piece_dropper_if.sv - game-side bundle between the board logic and piece_dropper
// master: board/game logic (drives occupancy, shape and move requests; receives piece)
// slave : piece_dropper (drives the four square positions and status pulses)
interface piece_dropper_if;

    logic [tetris_pkg::BOARD_ROWS-1:0][tetris_pkg::BOARD_COLS-1:0] board;
    logic [2:0] next_shape;
    logic       drop_tick;
    logic       soft_drop;
    logic       move_left;
    logic       move_right;
    logic [9:0] square1x, square1y;
    logic [9:0] square2x, square2y;
    logic [9:0] square3x, square3y;
    logic [9:0] square4x, square4y;
    logic       at_bottom;
    logic       game_over;
    logic       spawn_req;

    modport master (
        output board, next_shape, drop_tick, soft_drop, move_left, move_right,
        input  square1x, square1y, square2x, square2y,
        input  square3x, square3y, square4x, square4y,
        input  at_bottom, game_over, spawn_req
    );

    modport slave (
        input  board, next_shape, drop_tick, soft_drop, move_left, move_right,
        output square1x, square1y, square2x, square2y,
        output square3x, square3y, square4x, square4y,
        output at_bottom, game_over, spawn_req
    );

endinterface

// File: rtl/piece_fits.sv
// rtl/piece_fits.sv - combinational test that a piece placement is on the board and clear
// shape : piece shape
// col   : anchor column, two's complement so col-1 at column 0 reads as -1
// row   : anchor row, two's complement, one bit wider than the row register
// board : committed occupancy, board[r][c]
// fits  : 1 when all four cells are inside the board and unoccupied
module piece_fits
    import tetris_pkg::*;
(
    input  shape_t                                      shape,
    input  logic signed [4:0]                           col,
    input  logic signed [5:0]                           row,
    input  logic [BOARD_ROWS-1:0][BOARD_COLS-1:0]       board,
    output logic                                        fits
);

    cells_t     cells;
    logic [5:0] cc [4];
    logic [6:0] rr [4];
    logic [3:0] in_rng;
    logic [3:0] ok;

    assign cells = shape_cells(shape);

    for (genvar k = 0; k < 4; k++) begin : g_cell
        // Sign-extend the anchor one more bit so adding an offset never wraps.
        assign cc[k] = {col[4], col} + {4'b0, cells[k].dx};
        assign rr[k] = {row[5], row} + {5'b0, cells[k].dy};

        assign in_rng[k] = !cc[k][5] && (cc[k][4:0] < 5'(BOARD_COLS)) &&
                           !rr[k][6] && (rr[k][5:0] < 6'(BOARD_ROWS));

        // Only look the cell up once its coordinates are known to be legal.
        assign ok[k] = in_rng[k] &&
                       !(in_rng[k] ? board[rr[k][4:0]][cc[k][3:0]] : 1'b0);
    end

    assign fits = &ok;

endmodule

// File: rtl/piece_dropper.sv
// rtl/piece_dropper.sv - active tetromino controller: spawn, gravity, shifts, lock, game over
// Clk   : system clock
// Reset : synchronous, active-high
// bus   : piece_dropper_if.slave (board, next_shape, drop/move requests in;
//         four square pixel positions, at_bottom, game_over, spawn_req out)
module piece_dropper
    import tetris_pkg::*;
#(
    parameter int CELL      = 20,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 0,
    parameter int SETTLE    = 2,
    parameter int SPAWN_COL = 3
) (
    input logic             Clk,
    input logic             Reset,
    piece_dropper_if.slave  bus
);

    localparam logic [3:0] SPAWN_C  = 4'(SPAWN_COL);
    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t     state_q, state_d;
    shape_t     shape_q, shape_d;
    logic [3:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;

    shape_t            spawn_shape;
    logic signed [4:0] col_s, col_l, col_r, col_sp;
    logic signed [5:0] row_s, row_dn;
    logic              fits_spawn, fits_drop, fits_left, fits_right;
    logic              drop;

    assign spawn_shape = to_shape(bus.next_shape);
    assign drop        = bus.drop_tick | bus.soft_drop;

    assign col_s  = {1'b0, col_q};
    assign col_l  = col_s - 5'sd1;
    assign col_r  = col_s + 5'sd1;
    assign col_sp = {1'b0, SPAWN_C};
    assign row_s  = {1'b0, row_q};
    assign row_dn = row_s + 6'sd1;

    piece_fits u_fits_spawn (
        .shape (spawn_shape),
        .col   (col_sp),
        .row   (6'sd0),
        .board (bus.board),
        .fits  (fits_spawn)
    );

    piece_fits u_fits_drop (
        .shape (shape_q),
        .col   (col_s),
        .row   (row_dn),
        .board (bus.board),
        .fits  (fits_drop)
    );

    piece_fits u_fits_left (
        .shape (shape_q),
        .col   (col_l),
        .row   (row_s),
        .board (bus.board),
        .fits  (fits_left)
    );

    piece_fits u_fits_right (
        .shape (shape_q),
        .col   (col_r),
        .row   (row_s),
        .board (bus.board),
        .fits  (fits_right)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_SPAWN;
            shape_q <= SHAPE_I;
            col_q   <= SPAWN_C;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shape_q <= shape_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shape_d = shape_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SPAWN: begin
                // The new piece is loaded even when it collides so the final
                // frozen picture shows the piece that ended the game.
                shape_d = spawn_shape;
                col_d   = SPAWN_C;
                row_d   = '0;
                state_d = fits_spawn ? ST_FALL : ST_GAME_OVER;
            end
            ST_FALL: begin
                if (drop) begin
                    if (fits_drop) row_d = row_q + 5'd1;
                    else           state_d = ST_LOCK;
                end else if (bus.move_left ^ bus.move_right) begin
                    if (bus.move_left && fits_left)        col_d = col_q - 4'd1;
                    else if (bus.move_right && fits_right) col_d = col_q + 4'd1;
                end
            end
            ST_LOCK: begin
                state_d = ST_WAIT_CLEAR;
                cnt_d   = SETTLE_C;
            end
            ST_WAIT_CLEAR: begin
                // SETTLE idle cycles follow the placement pulse; SETTLE=0
                // still spends one cycle here before spawning.
                if (cnt_q <= 8'd1) state_d = ST_SPAWN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_GAME_OVER: begin
                state_d = ST_GAME_OVER;
            end
            default: begin
                state_d = ST_SPAWN;
            end
        endcase
    end

    assign bus.at_bottom = (state_q == ST_LOCK);
    assign bus.game_over = (state_q == ST_GAME_OVER);
    // Reset parks the FSM in SPAWN; the shape is only consumed once it is released.
    assign bus.spawn_req = (state_q == ST_SPAWN) && !Reset;

    cells_t     cur;
    logic [9:0] sx [4];
    logic [9:0] sy [4];

    assign cur = shape_cells(shape_q);

    for (genvar k = 0; k < 4; k++) begin : g_pix
        assign sx[k] = 10'(X_ORIGIN) + (10'(col_q) + 10'(cur[k].dx)) * 10'(CELL);
        assign sy[k] = 10'(Y_ORIGIN) + (10'(row_q) + 10'(cur[k].dy)) * 10'(CELL);
    end

    assign bus.square1x = sx[0];
    assign bus.square1y = sy[0];
    assign bus.square2x = sx[1];
    assign bus.square2y = sy[1];
    assign bus.square3x = sx[2];
    assign bus.square3y = sy[2];
    assign bus.square4x = sx[3];
    assign bus.square4y = sy[3];

endmodule

// File: tb/tb_piece_dropper.sv
// tb/tb_piece_dropper.sv - scoreboard bench for piece_dropper
module tb_piece_dropper;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    piece_dropper_if bus ();

    piece_dropper dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [82:0] v;
    } exp_t;

    exp_t sb[$];

    // Independent reference: square positions for shape/col/row plus the three flags.
    function automatic logic [82:0] model(input int sh, input int col, input int row,
                                          input logic ab, input logic go, input logic sr);
        int dx[4];
        int dy[4];
        int x;
        int y;
        logic [82:0] v;
        case (sh)
            1: begin dx = '{1, 2, 1, 2}; dy = '{0, 0, 1, 1}; end
            2: begin dx = '{0, 1, 2, 1}; dy = '{0, 0, 0, 1}; end
            3: begin dx = '{1, 2, 0, 1}; dy = '{0, 0, 1, 1}; end
            4: begin dx = '{0, 1, 1, 2}; dy = '{0, 0, 1, 1}; end
            5: begin dx = '{0, 1, 2, 2}; dy = '{0, 0, 0, 1}; end
            6: begin dx = '{0, 1, 2, 0}; dy = '{0, 0, 0, 1}; end
            default: begin dx = '{0, 1, 2, 3}; dy = '{0, 0, 0, 0}; end
        endcase
        v = '0;
        for (int k = 0; k < 4; k++) begin
            x = (col + dx[k]) * 20;
            y = (row + dy[k]) * 20;
            v[82 - 20*k -: 10] = x[9:0];
            v[72 - 20*k -: 10] = y[9:0];
        end
        v[2:0] = {ab, go, sr};
        return v;
    endfunction

    function automatic logic [82:0] snap();
        return {bus.square1x, bus.square1y, bus.square2x, bus.square2y,
                bus.square3x, bus.square3y, bus.square4x, bus.square4y,
                bus.at_bottom, bus.game_over, bus.spawn_req};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.drop_tick  = 1'b0;
        bus.soft_drop  = 1'b0;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
    endtask

    // Leaves the DUT just released from reset, sitting in SPAWN.
    task automatic do_reset(input int sh);
        clear_inputs();
        bus.next_shape = 3'(sh);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.board = '0;
        clear_inputs();
        bus.next_shape = 3'd0;
        reset = 1'b1;
        step();
        sb.push_back('{"reset_hold", model(0, 3, 0, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        reset = 1'b0;
        sb.push_back('{"reset_release_spawn", model(0, 3, 0, 0, 0, 1)});
        #1;
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        sb.push_back('{"reset_first_fall", model(0, 3, 0, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
    endtask

    task automatic test_shapes();
        exp_t e;
        bus.board = '0;
        for (int s = 0; s < 8; s++) begin
            do_reset(s);
            sb.push_back('{$sformatf("spawn_shape_%0d", s), model((s == 7) ? 0 : s, 3, 0, 0, 0, 0)});
            step();
            e = sb.pop_front(); checks++;
            if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        end
    endtask

    task automatic test_o_drop();
        exp_t e;
        bus.board = '0;
        do_reset(1);
        step();
        bus.drop_tick = 1'b1;
        repeat (17) step();
        sb.push_back('{"o_row18", model(1, 3, 18, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        sb.push_back('{"o_lock", model(1, 3, 18, 1, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        bus.drop_tick = 1'b0;
        bus.next_shape = 3'd4;
        for (int i = 1; i <= SETTLE + 1; i++) begin
            sb.push_back('{$sformatf("o_settle_%0d", i), model(1, 3, 18, 0, 0, (i == SETTLE + 1))});
            step();
            e = sb.pop_front(); checks++;
            if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        end
        sb.push_back('{"next_z_spawned", model(4, 3, 0, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
    endtask

    task automatic test_move();
        exp_t e;
        int col;
        bus.board = '0;
        do_reset(0);
        step();
        col = 3;
        bus.move_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            col = (col > 0) ? col - 1 : 0;
            sb.push_back('{$sformatf("move_left_%0d", i), model(0, col, 0, 0, 0, 0)});
            step();
            e = sb.pop_front(); checks++;
            if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        end
        bus.move_left = 1'b0;
        bus.move_right = 1'b1;
        for (int i = 0; i < 8; i++) begin
            col = (col < 6) ? col + 1 : 6;
            sb.push_back('{$sformatf("move_right_%0d", i), model(0, col, 0, 0, 0, 0)});
            step();
            e = sb.pop_front(); checks++;
            if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        end
        clear_inputs();
    endtask

    task automatic test_row_full();
        exp_t e;
        bus.board = '0;
        bus.board[10] = '1;
        do_reset(2);
        step();
        bus.drop_tick = 1'b1;
        repeat (7) step();
        sb.push_back('{"t_row8", model(2, 3, 8, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        sb.push_back('{"t_lock_on_row10", model(2, 3, 8, 1, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        bus.drop_tick = 1'b0;
        sb.push_back('{"t_at_bottom_once", model(2, 3, 8, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
    endtask

    task automatic test_game_over();
        exp_t e;
        bus.board = '0;
        bus.board[0] = 10'b0001111000;
        do_reset(0);
        sb.push_back('{"go_spawn_req", model(0, 3, 0, 0, 0, 1)});
        #1;
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        sb.push_back('{"go_enter", model(0, 3, 0, 0, 1, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        bus.next_shape = 3'd1;
        for (int i = 0; i < 8; i++) begin
            bus.drop_tick  = (i % 4 == 0);
            bus.move_left  = (i % 4 == 1);
            bus.move_right = (i % 4 == 2);
            bus.soft_drop  = (i % 4 == 3);
            sb.push_back('{$sformatf("go_frozen_%0d", i), model(0, 3, 0, 0, 1, 0)});
            step();
            e = sb.pop_front(); checks++;
            if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        end
        clear_inputs();
    endtask

    task automatic test_combo();
        exp_t e;
        bus.board = '0;
        do_reset(0);
        step();
        bus.drop_tick = 1'b1;
        bus.move_left = 1'b1;
        bus.move_right = 1'b1;
        sb.push_back('{"drop_beats_moves", model(0, 3, 1, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        bus.drop_tick = 1'b0;
        sb.push_back('{"left_right_cancel", model(0, 3, 1, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        clear_inputs();
        bus.soft_drop = 1'b1;
        sb.push_back('{"soft_drop", model(0, 3, 2, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        clear_inputs();
    endtask

    task automatic test_reset_in_lock();
        exp_t e;
        bus.board = '0;
        do_reset(1);
        step();
        bus.drop_tick = 1'b1;
        repeat (18) step();
        sb.push_back('{"lock_before_reset", model(1, 3, 18, 1, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        bus.drop_tick = 1'b0;
        reset = 1'b1;
        sb.push_back('{"reset_in_lock", model(0, 3, 0, 0, 0, 0)});
        step();
        e = sb.pop_front(); checks++;
        if (snap() !== e.v) begin failures++; $display("FAIL %s got=%h want=%h", e.name, snap(), e.v); end
        reset = 1'b0;
    endtask

    initial begin
        bus.board = '0;
        bus.next_shape = 3'd0;
        clear_inputs();
        test_reset();
        test_shapes();
        test_o_drop();
        test_move();
        test_row_full();
        test_game_over();
        test_combo();
        test_reset_in_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
